// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit : parametrised program counter for the multi-cycle/pipelined core.
//
// Provides a configurable step and reset vector, stall, branch/jump redirect,
// a one-entry pending-redirect buffer for redirects that arrive while stalled,
// and a HALT state with resume.
//
// Parameters
//   WIDTH       PC width in bits
//   INC         PC step per instruction (1 = word IMEM, 4 = byte IMEM)
//   RESET_ADDR  PC value loaded on reset
//   HALT_CODE   pc_src value that marks a halt instruction
//
// Ports
//   clk              in   clock, all state updates on posedge
//   rst              in   synchronous reset, active-low
//   pc_src           in   opcode field of current instruction
//   stall            in   1 = hold PC this cycle
//   redirect_valid   in   1 = branch/jump taken this cycle
//   redirect_target  in   target address for redirect
//   resume           in   1 = leave HALT, continue at pc+INC
//   pc               out  current instruction address (registered)
//   pc_plus_inc      out  pc+INC, combinational, wraps mod 2^WIDTH
//   halted           out  1 while in HALT (registered; this is the FSM state)
//   pend_valid       out  1 while a redirect is buffered (registered)
//
// Handshake: redirect_valid is a single-cycle pulse with no ready; it is
// always accepted on the posedge it is sampled. While stalled it lands in the
// pending buffer (newest wins); otherwise it loads pc directly.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned        WIDTH      = 32,
  parameter int unsigned        INC        = 1,
  parameter logic [WIDTH-1:0]   RESET_ADDR = '0,
  parameter logic [6:0]         HALT_CODE  = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       pc_src,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             halted,
  output logic             pend_valid
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;

  // Truncating add: all-ones + INC wraps silently.
  assign pc_plus_inc = pc_q + INC_W;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;

    case (state_q)
      S_RUN: begin
        if (stall) begin
          // Hold pc; park any redirect so it is not lost. pc_src is ignored
          // so a stalled halt instruction cannot take effect.
          if (redirect_valid) begin
            pend_d      = 1'b1;
            pend_addr_d = redirect_target;
          end
        end else if (redirect_valid) begin
          // A live redirect supersedes whatever was parked.
          pc_d   = redirect_target;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_addr_q;
          pend_d = 1'b0;
        end else if (pc_src == HALT_CODE) begin
          // Only reachable with the buffer empty, so HALT never holds a pending redirect.
          state_d = S_HALT;
        end else begin
          pc_d = pc_plus_inc;
        end
      end

      S_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = S_RUN;
        end else if (resume) begin
          // Step past the halt instruction.
          pc_d    = pc_plus_inc;
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign pend_valid = pend_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit : self-checking bench for pc_unit.
// Two instances share one stimulus stream: a 32-bit byte-addressed PC with a
// non-zero reset vector, and an 8-bit PC that exercises wrap-around.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [6:0]  pc_src;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        resume;

  logic [31:0] pc_a, ppi_a;
  logic        halted_a, pend_a;
  logic [7:0]  pc_b, ppi_b;
  logic        halted_b, pend_b;

  pc_unit #(.WIDTH(32), .INC(4), .RESET_ADDR(32'h100), .HALT_CODE(7'h7F)) dut_a (
    .clk(clk), .rst(rst), .pc_src(pc_src), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .resume(resume), .pc(pc_a), .pc_plus_inc(ppi_a),
    .halted(halted_a), .pend_valid(pend_a)
  );

  pc_unit #(.WIDTH(8), .INC(4), .RESET_ADDR(8'h00), .HALT_CODE(7'h7F)) dut_b (
    .clk(clk), .rst(rst), .pc_src(pc_src), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target[7:0]),
    .resume(resume), .pc(pc_b), .pc_plus_inc(ppi_b),
    .halted(halted_b), .pend_valid(pend_b)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        halt;
    logic        pend;
    logic [31:0] paddr;
  } mstate_t;

  mstate_t m_a, m_b;
  bit      m_valid = 1'b0;

  // Next architectural state from the written rules, using the inputs
  // present at the clock edge.
  function automatic mstate_t model_next(input mstate_t s, input logic [31:0] mask,
                                         input logic [31:0] rst_addr);
    mstate_t n = s;
    logic [31:0] tgt = redirect_target & mask;
    if (!rst) begin
      n.pc = rst_addr; n.halt = 1'b0; n.pend = 1'b0; n.paddr = 32'h0;
    end else if (s.halt) begin
      if (redirect_valid)   begin n.pc = tgt;                 n.halt = 1'b0; end
      else if (resume)      begin n.pc = (s.pc + 32'd4) & mask; n.halt = 1'b0; end
    end else if (stall) begin
      if (redirect_valid)   begin n.pend = 1'b1; n.paddr = tgt; end
    end else if (redirect_valid) begin
      n.pc = tgt; n.pend = 1'b0;
    end else if (s.pend) begin
      n.pc = s.paddr; n.pend = 1'b0;
    end else if (pc_src == 7'h7F) begin
      n.halt = 1'b1;
    end else begin
      n.pc = (s.pc + 32'd4) & mask;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_a <= model_next(m_a, 32'hFFFF_FFFF, 32'h100);
    m_b <= model_next(m_b, 32'h0000_00FF, 32'h0);
    if (!rst) m_valid <= 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc_a",   pc_a,              m_a.pc);
      check("ppi_a",  ppi_a,             m_a.pc + 32'd4);
      check("halt_a", {31'b0, halted_a}, {31'b0, m_a.halt});
      check("pend_a", {31'b0, pend_a},   {31'b0, m_a.pend});
      check("pc_b",   {24'b0, pc_b},     m_b.pc);
      check("ppi_b",  {24'b0, ppi_b},    (m_b.pc + 32'd4) & 32'hFF);
      check("halt_b", {31'b0, halted_b}, {31'b0, m_b.halt});
      check("pend_b", {31'b0, pend_b},   {31'b0, m_b.pend});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    resume = 1'b0; pc_src = 7'h13;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_target = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b0;
    idle();

    // T1: reset then plain increments
    tick(); tick();
    check("t1_rst_pc",   pc_a, 32'h100);
    check("t1_rst_halt", {31'b0, halted_a}, 32'h0);
    check("t1_rst_pend", {31'b0, pend_a}, 32'h0);
    check("t1_model_pc", m_a.pc, 32'h100);
    exp_q.push_back(32'h104); exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_inc", pc_a, exp_q.pop_front());
    end

    // T2: halt holds, resume skips the halt instruction
    do_redirect(32'h14);
    check("t2_redir", pc_a, 32'h14);
    pc_src = 7'h7F;
    tick();
    check("t2_halted", {31'b0, halted_a}, 32'h1);
    check("t2_hold",   pc_a, 32'h14);
    pc_src = 7'h13; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold4", pc_a, 32'h14);
    end
    stall = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    check("t2_resume_pc", pc_a, 32'h18);
    check("t2_resume_h",  {31'b0, halted_a}, 32'h0);

    // T3: redirects during stall are buffered, newest wins
    do_redirect(32'h20);
    stall = 1'b1;
    do_redirect(32'h80);
    check("t3_pc_hold", pc_a, 32'h20);
    check("t3_pend",    {31'b0, pend_a}, 32'h1);
    do_redirect(32'hC0);
    pc_src = 7'h7F;
    tick();
    check("t3_no_halt_stall", {31'b0, halted_a}, 32'h0);
    pc_src = 7'h13; stall = 1'b0;
    tick();
    check("t3_pend_pc",  pc_a, 32'hC0);
    check("t3_pend_clr", {31'b0, pend_a}, 32'h0);
    stall = 1'b1;
    do_redirect(32'h300);
    stall = 1'b0; pc_src = 7'h7F;
    tick();
    check("t3_pend_over_halt", pc_a, 32'h300);
    check("t3_no_halt",        {31'b0, halted_a}, 32'h0);

    // T4: priorities
    pc_src = 7'h7F;
    do_redirect(32'h40);
    check("t4_redir_pc", pc_a, 32'h40);
    check("t4_redir_h",  {31'b0, halted_a}, 32'h0);
    tick();
    check("t4_halt", {31'b0, halted_a}, 32'h1);
    pc_src = 7'h13; resume = 1'b1;
    do_redirect(32'h200);
    resume = 1'b0;
    check("t4_wake_pc", pc_a, 32'h200);
    check("t4_wake_h",  {31'b0, halted_a}, 32'h0);

    // T5: wrap-around
    do_redirect(32'hFFFF_FFFC);
    check("t5_ppi_a", ppi_a, 32'h0);
    check("t5_pc_b",  {24'b0, pc_b}, 32'hFC);
    check("t5_ppi_b", {24'b0, ppi_b}, 32'h0);
    tick();
    check("t5_wrap_a", pc_a, 32'h0);
    check("t5_wrap_b", {24'b0, pc_b}, 32'h0);

    // T6: reset overrides halt, stall and pending
    pc_src = 7'h7F;
    tick();
    check("t6_halt", {31'b0, halted_a}, 32'h1);
    pc_src = 7'h13; stall = 1'b1; resume = 1'b1; rst = 1'b0;
    do_redirect(32'h600);
    check("t6_rst_halt_pc", pc_a, 32'h100);
    check("t6_rst_halt_h",  {31'b0, halted_a}, 32'h0);
    rst = 1'b1; resume = 1'b0;
    do_redirect(32'h700);
    check("t6_pend_set", {31'b0, pend_a}, 32'h1);
    rst = 1'b0;
    tick();
    check("t6_rst_pend",    {31'b0, pend_a}, 32'h0);
    check("t6_rst_pend_pc", pc_a, 32'h100);
    rst = 1'b1; idle();
    tick();
    check("t6_after_rel", pc_a, 32'h104);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 39) != 0);
      stall           = ($urandom_range(0, 2) == 0);
      redirect_valid  = ($urandom_range(0, 3) == 0);
      redirect_target = $urandom() & 32'hFFFF_FFFC;
      resume          = ($urandom_range(0, 4) == 0);
      pc_src          = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
